// File: rtl/axis_pkt_sched.sv
// axis_pkt_sched: AXI-Stream packet scheduler.
// Emits pkt_count packets of trans_size beats each, separated by gap idle
// cycles. It drives the stream handshake, TLAST and TID, and pulses gen_en
// once per accepted beat so an external data generator stays in step.
// An abort stops the run at the next packet boundary and never mid-packet.
module axis_pkt_sched #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] trans_size,
  input  logic [CNT_W-1:0] pkt_count,
  input  logic [7:0]       gap,
  input  logic             TREADY,
  output logic             TVALID,
  output logic             TLAST,
  output logic [7:0]       TID,
  output logic             gen_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [LEN_W-1:0] size_r, size_nxt_s;
  logic [CNT_W-1:0] npkt_r, npkt_nxt_s;
  logic [7:0]       gap_len_r, gap_len_nxt_s;
  logic [LEN_W-1:0] beat_cnt_r, beat_nxt_s;
  logic [CNT_W-1:0] pkt_cnt_r, pkt_nxt_s;
  logic [7:0]       gap_cnt_r, gap_cnt_nxt_s;
  logic             abort_pend_r, abort_nxt_s;
  logic             tvalid_r, tlast_r, busy_r, done_r;
  logic             hs_s;

  // A beat is transferred only when both sides agree.
  assign hs_s   = tvalid_r & TREADY;
  assign gen_en = hs_s;

  assign TVALID = tvalid_r;
  assign TLAST  = tlast_r;
  assign TID    = pkt_cnt_r[7:0];
  assign busy   = busy_r;
  assign done   = done_r;

  // Next-state, counter and latched-parameter logic.
  always_comb begin
    state_nxt_s   = state_r;
    size_nxt_s    = size_r;
    npkt_nxt_s    = npkt_r;
    gap_len_nxt_s = gap_len_r;
    beat_nxt_s    = beat_cnt_r;
    pkt_nxt_s     = pkt_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    // Abort is sticky for the whole run; it is ignored while idle.
    abort_nxt_s   = abort_pend_r | (abort & (state_r != ST_IDLE));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          size_nxt_s    = trans_size;
          npkt_nxt_s    = pkt_count;
          gap_len_nxt_s = gap;
          beat_nxt_s    = {LEN_W{1'b0}};
          pkt_nxt_s     = {CNT_W{1'b0}};
          gap_cnt_nxt_s = 8'd0;
          if ((trans_size == {LEN_W{1'b0}}) || (pkt_count == {CNT_W{1'b0}})) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (hs_s) begin
          if (beat_cnt_r == (size_r - LEN_ONE)) begin
            // Packet boundary: the only point where a run may end early.
            beat_nxt_s = {LEN_W{1'b0}};
            pkt_nxt_s  = pkt_cnt_r + CNT_ONE;
            if ((pkt_cnt_r == (npkt_r - CNT_ONE)) || abort_nxt_s) begin
              state_nxt_s = ST_DONE;
            end else if (gap_len_r != 8'd0) begin
              state_nxt_s   = ST_GAP;
              gap_cnt_nxt_s = gap_len_r - 8'd1;
            end else begin
              state_nxt_s = ST_SEND;
            end
          end else begin
            beat_nxt_s = beat_cnt_r + LEN_ONE;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end

      ST_GAP: begin
        if (abort_nxt_s) begin
          state_nxt_s = ST_DONE;
        end else if (gap_cnt_r == 8'd0) begin
          state_nxt_s = ST_SEND;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - 8'd1;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        abort_nxt_s = 1'b0;
      end

      default: begin
        state_nxt_s = ST_IDLE;
        abort_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered stream/status outputs.
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      size_r       <= {LEN_W{1'b0}};
      npkt_r       <= {CNT_W{1'b0}};
      gap_len_r    <= 8'd0;
      beat_cnt_r   <= {LEN_W{1'b0}};
      pkt_cnt_r    <= {CNT_W{1'b0}};
      gap_cnt_r    <= 8'd0;
      abort_pend_r <= 1'b0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      size_r       <= size_nxt_s;
      npkt_r       <= npkt_nxt_s;
      gap_len_r    <= gap_len_nxt_s;
      beat_cnt_r   <= beat_nxt_s;
      pkt_cnt_r    <= pkt_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      abort_pend_r <= abort_nxt_s;
      tvalid_r     <= (state_nxt_s == ST_SEND);
      tlast_r      <= (state_nxt_s == ST_SEND) && (beat_nxt_s == (size_nxt_s - LEN_ONE));
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_axis_pkt_sched.sv
// Directed bench for axis_pkt_sched: back-to-back packets, inter-packet gap,
// TREADY back-pressure, abort at a packet boundary, empty run and
// mid-packet reset.
module tb_axis_pkt_sched;

  logic        ACLK;
  logic        RST;
  logic        start;
  logic        abort;
  logic [15:0] trans_size;
  logic [15:0] pkt_count;
  logic [7:0]  gap;
  logic        TREADY;
  logic        TVALID;
  logic        TLAST;
  logic [7:0]  TID;
  logic        gen_en;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  axis_pkt_sched #(.LEN_W(16), .CNT_W(16)) dut (
    .ACLK       (ACLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .trans_size (trans_size),
    .pkt_count  (pkt_count),
    .gap        (gap),
    .TREADY     (TREADY),
    .TVALID     (TVALID),
    .TLAST      (TLAST),
    .TID        (TID),
    .gen_en     (gen_en),
    .busy       (busy),
    .done       (done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full clock: outputs are then stable at the falling edge.
  task automatic cyc();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Issue a start and then scramble the run parameters, which must be ignored.
  task automatic start_run(input logic [15:0] sz, input logic [15:0] cnt, input logic [7:0] g);
    trans_size = sz;
    pkt_count  = cnt;
    gap        = g;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
    trans_size = 16'd7;
    pkt_count  = 16'd9;
    gap        = 8'd3;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_tvalid"}, {31'd0, TVALID}, 32'd0);
    check_val({tag, "_busy"},   {31'd0, busy},   32'd0);
    check_val({tag, "_done"},   {31'd0, done},   32'd0);
  endtask

  initial begin
    logic       prev_stall;
    logic       p_tlast;
    logic [7:0] p_tid;
    logic       seen_done;
    int         beats;

    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1; start = 1'b0; abort = 1'b0; TREADY = 1'b1;
    trans_size = 16'd0; pkt_count = 16'd0; gap = 8'd0;

    // Reset state.
    @(negedge ACLK);
    check_val("rst_tvalid", {31'd0, TVALID}, 32'd0);
    check_val("rst_tlast",  {31'd0, TLAST},  32'd0);
    check_val("rst_tid",    {24'd0, TID},    32'd0);
    check_val("rst_busy",   {31'd0, busy},   32'd0);
    check_val("rst_done",   {31'd0, done},   32'd0);
    RST = 1'b0;
    cyc();
    check_idle("post_rst");

    // 4 beats x 2 packets, no gap, always ready.
    start_run(16'd4, 16'd2, 8'd0);
    for (int b = 0; b < 8; b++) begin
      check_val("t1_tvalid", {31'd0, TVALID}, 32'd1);
      check_val("t1_tlast",  {31'd0, TLAST},  ((b % 4) == 3) ? 32'd1 : 32'd0);
      check_val("t1_tid",    {24'd0, TID},    (b < 4) ? 32'd0 : 32'd1);
      check_val("t1_gen_en", {31'd0, gen_en}, 32'd1);
      check_val("t1_done",   {31'd0, done},   32'd0);
      cyc();
    end
    check_val("t1_done_pulse", {31'd0, done},   32'd1);
    check_val("t1_done_busy",  {31'd0, busy},   32'd1);
    check_val("t1_done_tv",    {31'd0, TVALID}, 32'd0);
    cyc();
    check_idle("t1_end");

    // 3 beats x 2 packets with a 5-cycle gap.
    start_run(16'd3, 16'd2, 8'd5);
    for (int b = 0; b < 3; b++) begin
      check_val("t2_p0_tvalid", {31'd0, TVALID}, 32'd1);
      check_val("t2_p0_tlast",  {31'd0, TLAST},  (b == 2) ? 32'd1 : 32'd0);
      check_val("t2_p0_tid",    {24'd0, TID},    32'd0);
      cyc();
    end
    for (int g = 0; g < 5; g++) begin
      check_val("t2_gap_tvalid", {31'd0, TVALID}, 32'd0);
      check_val("t2_gap_busy",   {31'd0, busy},   32'd1);
      cyc();
    end
    for (int b = 0; b < 3; b++) begin
      check_val("t2_p1_tvalid", {31'd0, TVALID}, 32'd1);
      check_val("t2_p1_tlast",  {31'd0, TLAST},  (b == 2) ? 32'd1 : 32'd0);
      check_val("t2_p1_tid",    {24'd0, TID},    32'd1);
      cyc();
    end
    check_val("t2_done", {31'd0, done}, 32'd1);
    cyc();
    check_idle("t2_end");

    // 16 beats under random back-pressure; the first cycle always stalls.
    start_run(16'd16, 16'd1, 8'd0);
    prev_stall = 1'b0; p_tlast = 1'b0; p_tid = 8'd0; seen_done = 1'b0; beats = 0;
    for (int i = 0; i < 300 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (prev_stall) begin
          check_val("t3_stall_tvalid", {31'd0, TVALID}, 32'd1);
          check_val("t3_stall_tlast",  {31'd0, TLAST},  {31'd0, p_tlast});
          check_val("t3_stall_tid",    {24'd0, TID},    {24'd0, p_tid});
        end
        TREADY = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        if (gen_en) begin
          check_val("t3_tlast", {31'd0, TLAST}, (beats == 15) ? 32'd1 : 32'd0);
          beats++;
        end
        prev_stall = TVALID & ~TREADY;
        p_tlast    = TLAST;
        p_tid      = TID;
        cyc();
      end
    end
    check_val("t3_finished", {31'd0, seen_done}, 32'd1);
    check_val("t3_gen_en_count", beats, 32'd16);
    TREADY = 1'b1;
    cyc();
    check_idle("t3_end");

    // Abort on beat 2 of packet 0: packet 0 completes, no packet 1.
    start_run(16'd8, 16'd4, 8'd0);
    for (int b = 0; b < 8; b++) begin
      check_val("t4_tvalid", {31'd0, TVALID}, 32'd1);
      check_val("t4_tlast",  {31'd0, TLAST},  (b == 7) ? 32'd1 : 32'd0);
      check_val("t4_tid",    {24'd0, TID},    32'd0);
      abort = (b == 2);
      cyc();
    end
    abort = 1'b0;
    check_val("t4_done",    {31'd0, done},   32'd1);
    check_val("t4_done_tv", {31'd0, TVALID}, 32'd0);
    cyc();
    check_idle("t4_end");
    cyc();
    check_idle("t4_stay");

    // Empty run: busy for one cycle together with done.
    start_run(16'd4, 16'd0, 8'd0);
    check_val("t5_busy",   {31'd0, busy},   32'd1);
    check_val("t5_done",   {31'd0, done},   32'd1);
    check_val("t5_tvalid", {31'd0, TVALID}, 32'd0);
    cyc();
    check_idle("t5_end");

    // Reset during packet 1, then a fresh run restarts at TID 0.
    start_run(16'd2, 16'd3, 8'd0);
    cyc();
    cyc();
    check_val("t6_pre_tid",    {24'd0, TID},    32'd1);
    check_val("t6_pre_tvalid", {31'd0, TVALID}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check_val("t6_rst_tvalid", {31'd0, TVALID}, 32'd0);
    check_val("t6_rst_tlast",  {31'd0, TLAST},  32'd0);
    check_val("t6_rst_tid",    {24'd0, TID},    32'd0);
    check_val("t6_rst_busy",   {31'd0, busy},   32'd0);
    check_val("t6_rst_gen_en", {31'd0, gen_en}, 32'd0);
    cyc();
    RST = 1'b0;
    cyc();
    check_idle("t6_no_resume");
    start_run(16'd2, 16'd1, 8'd0);
    for (int b = 0; b < 2; b++) begin
      check_val("t6_new_tvalid", {31'd0, TVALID}, 32'd1);
      check_val("t6_new_tid",    {24'd0, TID},    32'd0);
      check_val("t6_new_tlast",  {31'd0, TLAST},  (b == 1) ? 32'd1 : 32'd0);
      cyc();
    end
    check_val("t6_done", {31'd0, done}, 32'd1);
    cyc();
    check_idle("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_pkt_sched.md
AXIS_PKT_SCHED -- requirements
Module: axis_pkt_sched

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, meaning the width of the beat counter and trans_size.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the packet counter and pkt_count.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port ACLK, input, 1, the sole clock, rising edge.
REQ-005 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, which requests a run and is sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1, which requests a stop at the next packet boundary.
REQ-008 The block SHALL have port trans_size, input, LEN_W, giving the beats per packet.
REQ-009 The block SHALL have port pkt_count, input, CNT_W, giving the packets per run.
REQ-010 The block SHALL have port gap, input, 8, giving the idle cycles between packets.
REQ-011 The block SHALL have port TREADY, input, 1, the downstream ready.
REQ-012 The block SHALL have port TVALID, output, 1, the stream valid.
REQ-013 The block SHALL have port TLAST, output, 1, marking the final beat of a packet.
REQ-014 The block SHALL have port TID, output, 8, the packet index modulo 256.
REQ-015 The block SHALL have port gen_en, output, 1, which advances the data generator by one word.
REQ-016 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-018 The block SHALL implement the states IDLE, SEND, GAP and DONE.
REQ-019 When start=1 in IDLE, the block SHALL latch trans_size, pkt_count and gap, clear the beat and packet counters, and go to SEND, or to DONE if either latched size is 0.
REQ-020 TVALID SHALL be registered, equal 1 exactly while in SEND, and first rise on the cycle after the start edge.
REQ-021 A beat SHALL be counted only on a cycle with TVALID=1 and TREADY=1; gen_en SHALL equal TVALID AND TREADY combinationally.
REQ-022 TLAST SHALL be 1 exactly when TVALID=1 and the beat count equals the latched trans_size minus 1.
REQ-023 Once TVALID is asserted, TVALID, TLAST and TID SHALL hold stable until the handshake completes, with no deassertion while TREADY=0.
REQ-024 On the TLAST handshake, the block SHALL increment the packet counter and clear the beat counter.
REQ-025 After the TLAST handshake, the block SHALL go to DONE if the last packet is complete or an abort is pending.
REQ-026 After the TLAST handshake, when more packets remain and no abort is pending, the block SHALL go to GAP if the latched gap is greater than 0, else stay in SEND.
REQ-027 With gap=0, packets SHALL run back-to-back with TVALID continuously high.
REQ-028 GAP SHALL last exactly the latched gap cycles with TVALID=0, then return to SEND.
REQ-029 abort SHALL be captured into a sticky pending flag at any time while busy=1.
REQ-030 A pending abort SHALL never truncate a packet mid-stream.
REQ-031 An abort seen in GAP SHALL go to DONE on the next cycle.
REQ-032 An abort in IDLE SHALL be ignored.
REQ-033 TID SHALL equal the packet counter bits [7:0], wrapping from 255 to 0.
REQ-034 DONE SHALL last one cycle with done=1, then go to IDLE and clear the pending abort.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 Input changes on trans_size, pkt_count or gap during a run SHALL have no effect on that run.
REQ-037 All counter arithmetic SHALL be unsigned; a trans_size of 2^LEN_W-1 SHALL complete without counter overflow.

Reset
REQ-038 With RST=1, the block SHALL set TVALID=0, TLAST=0, TID=0, busy=0, done=0, all counters and latched values to 0, the pending abort to 0, and the state to IDLE, asynchronously.
REQ-039 Reset asserted mid-packet SHALL drop TVALID immediately; the block SHALL resume only on a new start after RST deasserts.
REQ-040 The first start SHALL be accepted no earlier than the first ACLK edge after RST deasserts.

Verification
REQ-041 The bench SHALL cover: trans_size=4, pkt_count=2, gap=0, TREADY=1 -> 8 consecutive TVALID beats, TLAST on beats 4 and 8, TID 0 then 1, done pulse 1 cycle after beat 8.
REQ-042 The bench SHALL cover: trans_size=3, pkt_count=2, gap=5 -> exactly 5 TVALID=0 cycles between the packets.
REQ-043 The bench SHALL cover: random TREADY stalls with trans_size=16 -> TVALID and TLAST stable during stalls, gen_en count equal to 16.
REQ-044 The bench SHALL cover: abort on beat 2 of packet 0 with trans_size=8 and pkt_count=4 -> packet 0 completes all 8 beats, no packet 1, done pulse follows.
REQ-045 The bench SHALL cover: pkt_count=0 -> no TVALID, busy high for 1 cycle, done pulses.
REQ-046 The bench SHALL cover: RST pulsed mid-packet -> all outputs 0 immediately; a new start then begins with TID=0.
